// File: rtl/plot_sink.sv
// Pixel-plot consumer: a plot FIFO feeds a 3-bit-per-pixel framebuffer, with a clear
// engine that fills the buffer and a raster scan engine that streams it out.
module plot_sink #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       plot,
  output logic       busy,
  output logic [7:0] drop_count,
  output logic [7:0] oob_count,
  input  logic       clear_req,
  input  logic [2:0] clear_colour,
  output logic       clearing,
  input  logic       scan_start,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [2:0] scan_colour,
  output logic       scan_done
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int PW   = $clog2(FIFO_DEPTH);

  typedef enum logic {C_IDLE, C_FILL} c_state_t;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_HOLD} s_state_t;

  // Callers only pass in-range coordinates, so the product fits in AW bits.
  function automatic logic [AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  logic [17:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [PW:0]   count_r;
  logic [17:0]   head_s;
  logic          in_range_s, full_s, push_s, pop_s;
  logic [7:0]    drop_r, oob_r;

  c_state_t      c_state_r, c_next_s;
  logic [AW-1:0] clear_addr_r;
  logic [2:0]    clear_colour_r;
  logic          clear_last_s;

  logic [2:0]    fb_mem [NPIX];
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s, rd_addr_s;
  logic [2:0]    wr_data_s, rd_data_r;

  s_state_t      s_state_r, s_next_s;
  logic [7:0]    idx_x_r, scan_x_r;
  logic [6:0]    idx_y_r, scan_y_r;
  logic [2:0]    scan_colour_r;
  logic          scan_valid_r, scan_done_r, x_wrap_s, scan_last_s;

  assign in_range_s   = ({24'd0, in_x} < 32'(WIDTH)) && ({25'd0, in_y} < 32'(HEIGHT));
  assign full_s       = (count_r == (PW+1)'(FIFO_DEPTH));
  assign push_s       = plot && in_range_s && !full_s;
  assign pop_s        = (count_r != (PW+1)'(0)) && (c_state_r == C_IDLE);
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign clear_last_s = (clear_addr_r == AW'(NPIX - 1));
  assign x_wrap_s     = (idx_x_r == 8'(WIDTH - 1));
  assign scan_last_s  = x_wrap_s && (idx_y_r == 7'(HEIGHT - 1));
  assign rd_addr_s    = pix_addr(idx_x_r, idx_y_r);

  assign busy        = full_s;
  assign drop_count  = drop_r;
  assign oob_count   = oob_r;
  assign clearing    = (c_state_r == C_FILL);
  assign scan_valid  = scan_valid_r;
  assign scan_x      = scan_x_r;
  assign scan_y      = scan_y_r;
  assign scan_colour = scan_colour_r;
  assign scan_done   = scan_done_r;

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage (no reset needed, guarded by occupancy)
  always_ff @(posedge clock) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= {in_x, in_y, in_colour};
  end

  // Saturating drop / out-of-range counters; out-of-range wins over full
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      drop_r <= 8'd0;
      oob_r  <= 8'd0;
    end else begin
      if (plot && !in_range_s && (oob_r != 8'hFF))          oob_r  <= oob_r + 8'd1;
      if (plot && in_range_s && full_s && (drop_r != 8'hFF)) drop_r <= drop_r + 8'd1;
    end
  end

  // Clear engine next state
  always_comb begin
    c_next_s = c_state_r;
    case (c_state_r)
      C_IDLE:  if (clear_req) c_next_s = C_FILL; else c_next_s = C_IDLE;
      C_FILL:  if (clear_last_s) c_next_s = C_IDLE; else c_next_s = C_FILL;
      default: c_next_s = C_IDLE;
    endcase
  end

  // Clear engine state, fill address and latched colour
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      c_state_r      <= C_IDLE;
      clear_addr_r   <= AW'(0);
      clear_colour_r <= 3'd0;
    end else begin
      c_state_r <= c_next_s;
      if ((c_state_r == C_IDLE) && clear_req) begin
        clear_addr_r   <= AW'(0);
        clear_colour_r <= clear_colour;
      end else if (c_state_r == C_FILL) begin
        clear_addr_r <= clear_addr_r + AW'(1);
      end
    end
  end

  // Single write port shared by the clear engine and the FIFO drain
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = AW'(0);
    wr_data_s = 3'd0;
    if (c_state_r == C_FILL) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clear_addr_r;
      wr_data_s = clear_colour_r;
    end else begin
      wr_en_s   = pop_s;
      wr_addr_s = pix_addr(head_s[17:10], head_s[9:3]);
      wr_data_s = head_s[2:0];
    end
  end

  // Framebuffer: read-before-write on a same-address collision
  always_ff @(posedge clock) begin
    if (wr_en_s) fb_mem[wr_addr_s] <= wr_data_s;
    rd_data_r <= fb_mem[rd_addr_s];
  end

  // Scan engine next state
  always_comb begin
    s_next_s = s_state_r;
    case (s_state_r)
      S_IDLE:  if (scan_start) s_next_s = S_READ; else s_next_s = S_IDLE;
      S_READ:  s_next_s = S_WAIT;
      S_WAIT:  s_next_s = S_HOLD;
      S_HOLD: begin
        if (!scan_ready)      s_next_s = S_HOLD;
        else if (scan_last_s) s_next_s = S_IDLE;
        else                  s_next_s = S_READ;
      end
      default: s_next_s = S_IDLE;
    endcase
  end

  // Scan index and registered pixel outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_state_r     <= S_IDLE;
      idx_x_r       <= 8'd0;
      idx_y_r       <= 7'd0;
      scan_x_r      <= 8'd0;
      scan_y_r      <= 7'd0;
      scan_colour_r <= 3'd0;
      scan_valid_r  <= 1'b0;
      scan_done_r   <= 1'b0;
    end else begin
      s_state_r   <= s_next_s;
      scan_done_r <= 1'b0;
      case (s_state_r)
        S_IDLE: begin
          if (scan_start) begin
            idx_x_r <= 8'd0;
            idx_y_r <= 7'd0;
          end
        end
        S_WAIT: begin
          scan_x_r      <= idx_x_r;
          scan_y_r      <= idx_y_r;
          scan_colour_r <= rd_data_r;
          scan_valid_r  <= 1'b1;
        end
        S_HOLD: begin
          if (scan_ready) begin
            scan_valid_r <= 1'b0;
            if (scan_last_s) begin
              scan_done_r <= 1'b1;
            end else if (x_wrap_s) begin
              idx_x_r <= 8'd0;
              idx_y_r <= idx_y_r + 7'd1;
            end else begin
              idx_x_r <= idx_x_r + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink, run with a reduced HEIGHT to keep full clears/scans short.
module tb_plot_sink;
  localparam int W = 160;
  localparam int H = 16;
  localparam int N = W * H;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       busy;
    logic [7:0] drop;
    logic [7:0] oob;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n, plot, clear_req, scan_start, scan_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour, clear_colour;
  logic       busy, clearing, scan_valid, scan_done;
  logic [7:0] drop_count, oob_count, scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;

  int         checks = 0;
  int         errors = 0;
  int         done_seen;
  logic [2:0] exp_fb [N];
  vec_t       tbl [16];

  plot_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .plot(plot), .busy(busy), .drop_count(drop_count), .oob_count(oob_count),
    .clear_req(clear_req), .clear_colour(clear_colour), .clearing(clearing),
    .scan_start(scan_start), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_x(scan_x), .scan_y(scan_y), .scan_colour(scan_colour), .scan_done(scan_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for the next pixel and compares it to the model
  task automatic expect_pixel(input int idx, output int waited);
    int n = 0;
    while (!scan_valid && n < 8) begin
      if (scan_done) done_seen++;
      tick();
      n++;
    end
    waited = n;
    if (!scan_valid) chk("scan_valid_timeout", int'(scan_valid), 1);
    else chk($sformatf("pix%0d", idx), int'({scan_x, scan_y, scan_colour}),
             int'({8'(idx % W), 7'(idx / W), exp_fb[idx]}));
  endtask

  task automatic scan_full();
    int w;
    int total = 0;
    done_seen = 0;
    scan_ready = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      expect_pixel(i, w);
      total += w;
      tick();
    end
    chk("scan_done_pulse", int'(scan_done), 1);
    tick();
    chk("scan_done_clear", int'(scan_done), 0);
    chk("scan_done_early", done_seen, 0);
    chk("scan_rate", total, 2 * N);
  endtask

  task automatic start_clear(input logic [2:0] c);
    clear_colour = c;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < N; k++) exp_fb[k] = c;
  endtask

  task automatic wait_clear(input int already);
    int cnt = already;
    while (clearing && cnt < 2 * N) begin
      cnt++;
      tick();
    end
    chk("clear_len", cnt, N);
  endtask

  initial begin
    int w;
    int cc;
    logic [2:0] pcol [8];
    pcol = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, 8'(20 + k), 7'd3, pcol[k], (k == 7), 8'd0, 8'd0};
    tbl[8]  = '{1'b1, 8'd40,  7'd3,   3'd5, 1'b1, 8'd1, 8'd0};
    tbl[9]  = '{1'b1, 8'd41,  7'd3,   3'd5, 1'b1, 8'd2, 8'd0};
    tbl[10] = '{1'b1, 8'd42,  7'd3,   3'd5, 1'b1, 8'd3, 8'd0};
    tbl[11] = '{1'b1, 8'd43,  7'd3,   3'd5, 1'b1, 8'd4, 8'd0};
    tbl[12] = '{1'b1, 8'd160, 7'd0,   3'd6, 1'b1, 8'd4, 8'd1};
    tbl[13] = '{1'b1, 8'd0,   7'd16,  3'd6, 1'b1, 8'd4, 8'd2};
    tbl[14] = '{1'b1, 8'd0,   7'd120, 3'd6, 1'b1, 8'd4, 8'd3};
    tbl[15] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd4, 8'd3};

    reset_n = 1'b0; plot = 1'b0; clear_req = 1'b0; scan_start = 1'b0; scan_ready = 1'b0;
    in_x = 8'd0; in_y = 7'd0; in_colour = 3'd0; clear_colour = 3'd0;
    @(negedge clock);
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_clearing", int'(clearing), 0);
    chk("rst_valid", int'(scan_valid), 0);
    chk("rst_done", int'(scan_done), 0);
    chk("rst_xyc", int'({scan_x, scan_y, scan_colour}), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_oob", int'(oob_count), 0);
    reset_n = 1'b1;
    tick();

    // Clear to 000 and read everything back
    start_clear(3'b000);
    wait_clear(0);
    scan_full();

    // Later plot to the same pixel wins
    plot = 1'b1; in_x = 8'd5; in_y = 7'd7; in_colour = 3'b101;
    tick();
    in_colour = 3'b010;
    tick();
    plot = 1'b0;
    repeat (4) tick();
    exp_fb[7 * W + 5] = 3'b010;
    scan_full();

    // Plots while the write engine is stalled by a clear
    start_clear(3'b000);
    cc = 0;
    for (int i = 0; i < 16; i++) begin
      plot = tbl[i].plot; in_x = tbl[i].x; in_y = tbl[i].y; in_colour = tbl[i].c;
      if (clearing) cc++;
      tick();
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_drop", i), int'(drop_count), int'(tbl[i].drop));
      chk($sformatf("tbl%0d_oob", i), int'(oob_count), int'(tbl[i].oob));
    end
    plot = 1'b0;
    wait_clear(cc);
    repeat (10) tick();
    chk("drain_busy", int'(busy), 0);
    chk("drain_drop", int'(drop_count), 4);
    chk("drain_oob", int'(oob_count), 3);
    for (int k = 0; k < 8; k++) exp_fb[3 * W + 20 + k] = pcol[k];
    scan_full();

    // Back-pressure on pixel (0,0), then row wrap
    scan_ready = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    expect_pixel(0, w);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", int'(scan_valid), 1);
      chk("hold_pix", int'({scan_x, scan_y, scan_colour}), int'({8'd0, 7'd0, exp_fb[0]}));
    end
    scan_ready = 1'b1;
    tick();
    for (int i = 1; i <= W + 1; i++) begin
      expect_pixel(i, w);
      tick();
    end
    scan_ready = 1'b0;
    expect_pixel(W + 2, w);

    // Reset in the middle of a clear and a scan
    start_clear(3'b110);
    repeat (1000) tick();
    chk("pre_rst_clearing", int'(clearing), 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_clearing", int'(clearing), 0);
    chk("mid_rst_valid", int'(scan_valid), 0);
    chk("mid_rst_done", int'(scan_done), 0);
    chk("mid_rst_xyc", int'({scan_x, scan_y, scan_colour}), 0);
    chk("mid_rst_drop", int'(drop_count), 0);
    chk("mid_rst_oob", int'(oob_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    tick();
    start_clear(3'b011);
    wait_clear(0);
    scan_full();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
Consumer end of the pixel-plot interface (x, y, colour, plot) that the animation blocks (staircase, sprites) drive.
- Plot requests are buffered in a small FIFO, bounds-checked, and written into an on-chip 3-bit-per-pixel framebuffer (WIDTH x HEIGHT).
- A raster scan engine reads the framebuffer back as a valid/ready pixel stream for display or collision logic.
- A clear engine fills the whole buffer with a colour on request.

Parameters:
WIDTH, 160, framebuffer columns; x valid range 0..WIDTH-1
HEIGHT, 120, framebuffer rows; y valid range 0..HEIGHT-1
FIFO_DEPTH, 8, plot FIFO entries (power of 2)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
in_x  in  8  plot x
in_y  in  7  plot y
in_colour  in  3  plot colour
plot  in  1  plot request, one pixel per cycle high
busy  out  1  FIFO full; a plot this cycle is dropped
drop_count  out  8  saturating count of plots dropped due to full
oob_count  out  8  saturating count of out-of-range plots discarded
clear_req  in  1  pulse: fill framebuffer with clear_colour
clear_colour  in  3  fill colour, sampled on accepted clear_req
clearing  out  1  high while the clear engine runs
scan_start  in  1  pulse: begin raster readout
scan_valid  out  1  scan_x/y/colour valid
scan_ready  in  1  consumer accepts the current pixel
scan_x  out  8  pixel x
scan_y  out  7  pixel y
scan_colour  out  3  pixel colour
scan_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
Memory
- WIDTH*HEIGHT x 3 RAM with one write port and one synchronous read port (1-cycle latency).
- Address = y*WIDTH + x.
- Read and write to the same address in the same cycle: the read returns old data.
- Contents are not changed by reset; they are undefined until the first clear.

Plot path
- On a clock edge with plot=1:
  - x>=WIDTH or y>=HEIGHT: discarded, oob_count++ (saturating at 255).
  - else if FIFO full (registered count==FIFO_DEPTH): dropped, drop_count++ (saturating). A pop in the same cycle does not make room.
  - else: pushed.
- busy = (count==FIFO_DEPTH), combinational from the registered count.

Write engine
- When the FIFO is non-empty and not clearing, pop one entry per cycle and write it to the RAM.
- A plot accepted at edge t is written at edge t+1 if the FIFO was empty. Reads issued at cycle >= t+2 see it.
- Entries are written strictly in arrival order; a later plot to the same pixel wins.

Clear engine, states C_IDLE and C_FILL
- C_IDLE -> C_FILL on clear_req: latch clear_colour, address=0, clearing=1.
- C_FILL writes one address per cycle, 0..WIDTH*HEIGHT-1, then returns to C_IDLE. Clear takes exactly WIDTH*HEIGHT cycles.
- The FIFO is not popped while clearing; plots still push and drop normally.
- clear_req during C_FILL is ignored.
- Plots queued before clear_req are written after the clear completes.

Scan engine, states S_IDLE, S_READ, S_WAIT, S_HOLD
- S_IDLE -> S_READ on scan_start; pixel index=0.
- S_READ: issue the read for the current index, go to S_WAIT.
- S_WAIT: load scan_x, scan_y, scan_colour; scan_valid=1; go to S_HOLD.
- S_HOLD: outputs stable while scan_ready=0. When scan_ready=1:
  - last index: scan_valid=0, scan_done pulses the next cycle, go to S_IDLE.
  - otherwise: index++ (x increments first, x wraps at WIDTH-1 and y increments), scan_valid=0, go to S_READ.
- Throughput is one pixel per 3 cycles when scan_ready is held high.
- scan_start outside S_IDLE is ignored.
- The scan runs concurrently with writes and clear; it sees whatever data is present at read time.

Reset (synchronous, any state)
- FIFO emptied; clear and scan engines go to idle (an in-progress clear is aborted).
- busy=0, clearing=0, scan_valid=0, scan_done=0, scan_x=0, scan_y=0, scan_colour=0, drop_count=0, oob_count=0.

Test Plan:
- clear_req with clear_colour=3'b000 -> clearing high for exactly 19200 cycles; then a full scan returns colour 000 for all 19200 pixels and scan_done pulses once.
- Plot (5,7,3'b101), then (5,7,3'b010) on the next cycle, after a clear -> scan pixel (5,7)=010; all others 000.
- 12 back-to-back plots with the write engine stalled by clearing -> busy high after 8 pushes; drop_count=4; the 8 queued pixels appear after the clear finishes.
- Plots at (160,0) and (0,120) -> oob_count=2; no RAM write; drop_count unchanged.
- scan_ready held low 10 cycles on pixel (0,0) -> scan_valid and outputs stable; on release the next pixel is (1,0); pixel (159,0) is followed by (0,1).
- reset_n low mid-clear at address 5000 -> clearing=0 next cycle, counters zero, scan_valid=0; a new clear_req restarts from address 0.
